// File: rtl/fb_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_writer_pkg
//  Description : Shared screen geometry, widths and FSM encoding for fb_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_writer_pkg;

    localparam int H_RES     = 160;
    localparam int V_RES     = 120;
    localparam int FB_ADDR_W = 15;
    localparam int COLOR_W   = 12;
    localparam int FIFO_W    = FB_ADDR_W + COLOR_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fb_state_e;

endpackage
`default_nettype wire

// File: rtl/fb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fb_fifo
//  Description : Small synchronous write FIFO with a registered head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_fifo
    import fb_writer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FIFO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_full_cnt = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_cnt_one  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_ptr_one  = c_PTR_W'(1);

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d, w_rd_ptr_inc;
    logic [c_CNT_W-1:0] r_count_q, w_count_d;
    logic [WIDTH-1:0]   r_head_q, w_head_d;
    logic               w_push, w_pop;

    assign o_full       = (r_count_q == c_full_cnt);
    assign o_empty      = (r_count_q == '0);
    assign o_head       = r_head_q;
    assign w_push       = i_push && !o_full;
    assign w_pop        = i_pop && !o_empty;
    assign w_rd_ptr_inc = r_rd_ptr_q + c_ptr_one;

    always_comb begin
        w_wr_ptr_d = w_push ? (r_wr_ptr_q + c_ptr_one) : r_wr_ptr_q;
        w_rd_ptr_d = w_pop ? w_rd_ptr_inc : r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push && !w_pop) begin
            w_count_d = r_count_q + c_cnt_one;
        end else if (!w_push && w_pop) begin
            w_count_d = r_count_q - c_cnt_one;
        end
        // The head register mirrors mem[rd_ptr]; a lone entry being replaced
        // by a simultaneous push must take the incoming data directly.
        w_head_d = r_head_q;
        if (w_pop) begin
            if (r_count_q > c_cnt_one) begin
                w_head_d = r_mem_q[w_rd_ptr_inc];
            end else if (w_push) begin
                w_head_d = i_data;
            end
        end else if (o_empty && w_push) begin
            w_head_d = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            r_head_q   <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_head_q   <= w_head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fb_writer
//  Description : Queues pixel and full-screen fill writes into a framebuffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_writer #(
    parameter int H_RES = fb_writer_pkg::H_RES,
    parameter int V_RES = fb_writer_pkg::V_RES,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic [7:0]  CounterX,
    input  logic [7:0]  CounterY,
    input  logic [11:0] color,
    input  logic        fill_start,
    input  logic [11:0] fill_color,
    output logic        fill_done,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [11:0] fb_data,
    input  logic        fb_ack,
    output logic [15:0] drop_count,
    output logic        busy
);
    import fb_writer_pkg::*;

    localparam logic [FB_ADDR_W-1:0] c_h_res     = FB_ADDR_W'(H_RES);
    localparam logic [FB_ADDR_W-1:0] c_last_addr = FB_ADDR_W'(H_RES * V_RES - 1);
    localparam logic [8:0]           c_h_lim     = 9'(H_RES);
    localparam logic [8:0]           c_v_lim     = 9'(V_RES);
    localparam logic [15:0]          c_drop_max  = 16'hFFFF;

    fb_state_e              r_state_q, w_state_d;
    logic [FB_ADDR_W-1:0]   r_fill_addr_q, w_fill_addr_d;
    logic [COLOR_W-1:0]     r_fill_color_q, w_fill_color_d;
    logic [15:0]            r_drop_q, w_drop_d;
    logic                   w_push, w_pop, w_full, w_empty, w_in_range;
    logic                   w_px_ready, w_fill_done;
    logic [FIFO_W-1:0]      w_push_data, w_head;
    logic [FB_ADDR_W-1:0]   w_x_ext, w_y_ext, w_row_base, w_px_addr;

    assign w_x_ext    = FB_ADDR_W'(CounterX);
    assign w_y_ext    = FB_ADDR_W'(CounterY);
    assign w_in_range = ({1'b0, CounterX} < c_h_lim) && ({1'b0, CounterY} < c_v_lim);

    generate
        if (H_RES == 160) begin : g_addr_shift
            assign w_row_base = (w_y_ext << 7) + (w_y_ext << 5);
        end else begin : g_addr_mul
            assign w_row_base = w_y_ext * c_h_res;
        end
    endgenerate

    assign w_px_addr = w_row_base + w_x_ext;

    always_comb begin
        w_state_d      = r_state_q;
        w_fill_addr_d  = r_fill_addr_q;
        w_fill_color_d = r_fill_color_q;
        w_drop_d       = r_drop_q;
        w_push         = 1'b0;
        w_push_data    = '0;
        w_px_ready     = 1'b0;
        w_fill_done    = 1'b0;
        case (r_state_q)
            IDLE: begin
                w_px_ready = !rst_n && !w_full;
                if (px_valid && w_px_ready) begin
                    if (w_in_range) begin
                        w_push      = 1'b1;
                        w_push_data = {w_px_addr, color};
                    end else if (r_drop_q != c_drop_max) begin
                        w_drop_d = r_drop_q + 16'd1;
                    end
                end
                if (fill_start) begin
                    w_state_d      = FILL;
                    w_fill_addr_d  = '0;
                    w_fill_color_d = fill_color;
                end
            end
            FILL: begin
                if (!w_full) begin
                    w_push      = 1'b1;
                    w_push_data = {r_fill_addr_q, r_fill_color_q};
                    if (r_fill_addr_q == c_last_addr) begin
                        w_fill_done = !rst_n;
                        w_state_d   = IDLE;
                    end else begin
                        w_fill_addr_d = r_fill_addr_q + 15'd1;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state_q      <= IDLE;
            r_fill_addr_q  <= '0;
            r_fill_color_q <= '0;
            r_drop_q       <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_fill_addr_q  <= w_fill_addr_d;
            r_fill_color_q <= w_fill_color_d;
            r_drop_q       <= w_drop_d;
        end
    end

    fb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop      = fb_we && fb_ack;
    assign fb_we      = !w_empty && !rst_n;
    assign fb_addr    = w_head[FIFO_W-1:COLOR_W];
    assign fb_data    = w_head[COLOR_W-1:0];
    assign px_ready   = w_px_ready;
    assign fill_done  = w_fill_done;
    assign drop_count = r_drop_q;
    assign busy       = (r_state_q == FILL) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_fb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_writer
//  Description : Directed, table-driven self-checking bench for fb_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        px_valid;
    logic        px_ready;
    logic [7:0]  CounterX;
    logic [7:0]  CounterY;
    logic [11:0] color;
    logic        fill_start;
    logic [11:0] fill_color;
    logic        fill_done;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [11:0] fb_data;
    logic        fb_ack;
    logic [15:0] drop_count;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [11:0] c;
        logic        we;
        logic [14:0] addr;
        logic [15:0] drops;
    } vec_t;

    vec_t vecs [9];

    fb_writer #(
        .H_RES (160),
        .V_RES (120),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .CounterX   (CounterX),
        .CounterY   (CounterY),
        .color      (color),
        .fill_start (fill_start),
        .fill_color (fill_color),
        .fill_done  (fill_done),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_ack     (fb_ack),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] bp_addr [4];
        logic [11:0] bp_col  [4];
        logic [14:0] exp_a;
        int          writes, fdone, cyc;
        bit          order_err, ready_viol, in_fill, hit, fd_viol, we_viol;

        vecs[0] = '{8'd3,   8'd2,   12'hF00, 1'b1, 15'd323,   16'd0};
        vecs[1] = '{8'd160, 8'd0,   12'h111, 1'b0, 15'd0,     16'd1};
        vecs[2] = '{8'd0,   8'd120, 12'h222, 1'b0, 15'd0,     16'd2};
        vecs[3] = '{8'd0,   8'd0,   12'h0AB, 1'b1, 15'd0,     16'd2};
        vecs[4] = '{8'd159, 8'd119, 12'hFFF, 1'b1, 15'd19199, 16'd2};
        vecs[5] = '{8'd255, 8'd255, 12'h333, 1'b0, 15'd0,     16'd3};
        vecs[6] = '{8'd10,  8'd1,   12'h123, 1'b1, 15'd170,   16'd3};
        vecs[7] = '{8'd159, 8'd0,   12'h5A5, 1'b1, 15'd159,   16'd3};
        vecs[8] = '{8'd0,   8'd119, 12'h0C3, 1'b1, 15'd19040, 16'd3};

        bp_addr = '{15'd1, 15'd2, 15'd160, 15'd805};
        bp_col  = '{12'hA01, 12'hA02, 12'hA03, 12'hA04};

        rst_n = 1'b1; px_valid = 1'b0; CounterX = '0; CounterY = '0; color = '0;
        fill_start = 1'b0; fill_color = '0; fb_ack = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);
        chk("rst_px_ready", px_ready, 0);
        chk("rst_fill_done", fill_done, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b0;
        #1 chk("post_rst_px_ready", px_ready, 1);

        // Single pixels and drops
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            px_valid = 1'b1; CounterX = vecs[i].x; CounterY = vecs[i].y; color = vecs[i].c;
            #1 chk($sformatf("vec%0d_ready", i), px_ready, 1);
            @(negedge clk);
            px_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d_we", i), fb_we, vecs[i].we);
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_addr", i), fb_addr, vecs[i].addr);
                chk($sformatf("vec%0d_data", i), fb_data, vecs[i].c);
            end
            chk($sformatf("vec%0d_drops", i), drop_count, vecs[i].drops);
        end

        // Backpressure: five offered pixels, four fit
        @(negedge clk);
        fb_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            px_valid = 1'b1;
            CounterX = (i == 4) ? 8'd7 : 8'(bp_addr[i % 4] % 160);
            CounterY = (i == 4) ? 8'd7 : 8'(bp_addr[i % 4] / 160);
            color    = (i == 4) ? 12'hBAD : bp_col[i % 4];
            #1 chk($sformatf("bp%0d_ready", i), px_ready, (i < 4) ? 1 : 0);
            if (i > 0) chk($sformatf("bp%0d_head", i), fb_addr, bp_addr[0]);
            @(negedge clk);
        end
        px_valid = 1'b0;
        fb_ack   = 1'b1;
        #1 chk("bp_full_pop_ready", px_ready, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_drain%0d_we", i), fb_we, 1);
            chk($sformatf("bp_drain%0d_addr", i), fb_addr, bp_addr[i]);
            chk($sformatf("bp_drain%0d_data", i), fb_data, bp_col[i]);
            @(negedge clk);
        end
        chk("bp_drain_empty", fb_we, 0);

        // Full-screen fill, with a fill_start pulse during FILL that must be ignored
        fill_start = 1'b1; fill_color = 12'h00F;
        @(negedge clk);
        fill_start = 1'b0;
        writes = 0; fdone = 0; cyc = 0; exp_a = '0;
        order_err = 1'b0; ready_viol = 1'b0; in_fill = 1'b1;
        while (writes < 19200 && cyc < 20000) begin
            if (fb_we) begin
                if (fb_addr !== exp_a || fb_data !== 12'h00F) order_err = 1'b1;
                exp_a = exp_a + 15'd1;
                writes++;
            end
            if (fill_done === 1'b1) fdone++;
            if (in_fill && px_ready !== 1'b0) ready_viol = 1'b1;
            if (fill_done === 1'b1) in_fill = 1'b0;
            if (writes == 100) begin
                fill_start = 1'b1; fill_color = 12'hFFF;
            end else begin
                fill_start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("fill_writes", writes, 19200);
        chk("fill_order", order_err, 0);
        chk("fill_done_pulses", fdone, 1);
        chk("fill_px_ready_low", ready_viol, 0);
        chk("fill_drained_we", fb_we, 0);
        chk("fill_drained_busy", busy, 0);
        chk("fill_idle_ready", px_ready, 1);

        // Pixel and fill_start together, then reset in the middle of the fill
        px_valid = 1'b1; CounterX = 8'd4; CounterY = 8'd0; color = 12'hABC;
        fill_start = 1'b1; fill_color = 12'h0F0;
        #1 chk("mix_ready", px_ready, 1);
        @(negedge clk);
        px_valid = 1'b0; fill_start = 1'b0;
        #1;
        chk("mix_pixel_addr", fb_addr, 4);
        chk("mix_pixel_data", fb_data, 12'hABC);
        chk("mix_fill_ready", px_ready, 0);
        @(negedge clk);
        chk("mix_fill0_addr", fb_addr, 0);
        chk("mix_fill0_data", fb_data, 12'h0F0);
        hit = 1'b0; fd_viol = 1'b0; cyc = 0;
        while (!hit && cyc < 1000) begin
            if (fill_done === 1'b1) fd_viol = 1'b1;
            if (fb_we === 1'b1 && fb_addr == 15'd500) hit = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("abort_reached_500", hit, 1);
        rst_n = 1'b1;
        #1 chk("abort_no_done_at_edge", fill_done, 0);
        @(negedge clk);
        chk("abort_we", fb_we, 0);
        chk("abort_busy", busy, 0);
        rst_n = 1'b0;
        we_viol = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (fb_we !== 1'b0) we_viol = 1'b1;
            if (fill_done !== 1'b0) fd_viol = 1'b1;
        end
        chk("abort_stays_empty", we_viol, 0);
        chk("abort_no_fill_done", fd_viol, 0);
        chk("abort_drops_cleared", drop_count, 0);

        // Drop counter saturation
        px_valid = 1'b1; CounterX = 8'd200; CounterY = 8'd0;
        repeat (65534) @(negedge clk);
        chk("sat_fffe", drop_count, 16'hFFFE);
        @(negedge clk);
        chk("sat_ffff", drop_count, 16'hFFFF);
        @(negedge clk);
        chk("sat_hold", drop_count, 16'hFFFF);
        chk("sat_no_we", fb_we, 0);
        px_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
